// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with a one-cycle HOLD after reset, aligned redirects and wrap to RESET_VEC.
// Optional trap entry (Trap input, Epc output, TRAP_VEC) is built only when PC_TRAP_EN is defined.
module pc_unit #(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      STEP       = 4,
  parameter logic [WIDTH-1:0] RESET_VEC  = '0,
  parameter logic [WIDTH-1:0] ADDR_LIMIT = WIDTH'(40)
`ifdef PC_TRAP_EN
  ,
  parameter logic [WIDTH-1:0] TRAP_VEC   = WIDTH'(32'h20)
`endif
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Stall,
  input  logic             Redirect,
  input  logic [WIDTH-1:0] RedirectAddr,
`ifdef PC_TRAP_EN
  input  logic             Trap,
`endif
  output logic [WIDTH-1:0] PC,
  output logic             PCValid,
  output logic             Wrap,
  output logic             Misaligned
`ifdef PC_TRAP_EN
  ,
  output logic [WIDTH-1:0] Epc
`endif
);

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    ACT_IDLE,
    ACT_TRAP,
    ACT_JUMP,
    ACT_REJECT,
    ACT_STALL,
    ACT_STEP
  } action_t;

  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = STEP_W - WIDTH'(1);

  state_t           state_q;
  state_t           state_d;
  action_t          action;

  logic [WIDTH:0]   inc_sum;
  logic             inc_wraps;
  logic             jump_wraps;
  logic             addr_misaligned;

  logic [WIDTH-1:0] pc_d;
  logic             valid_d;
  logic             wrap_d;
  logic             mis_d;
`ifdef PC_TRAP_EN
  logic [WIDTH-1:0] epc_d;
`endif

  // The extra carry bit catches a sequential step that rolls past 2^WIDTH.
  assign inc_sum         = {1'b0, PC} + {1'b0, STEP_W};
  assign inc_wraps       = inc_sum[WIDTH] | (inc_sum[WIDTH-1:0] > ADDR_LIMIT);
  assign jump_wraps      = RedirectAddr > ADDR_LIMIT;
  assign addr_misaligned = |(RedirectAddr & ALIGN_MASK);

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!Reset_n) begin
      state_q <= HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: HOLD lasts exactly one cycle.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      HOLD:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = HOLD;
    endcase
  end

  // Action select; trap is applied last so it overrides redirect and stall.
  always_comb begin
    action = ACT_IDLE;
    if (state_q == RUN) begin
      if (Redirect) begin
        action = addr_misaligned ? ACT_REJECT : ACT_JUMP;
      end else if (Stall) begin
        action = ACT_STALL;
      end else begin
        action = ACT_STEP;
      end
`ifdef PC_TRAP_EN
      if (Trap) begin
        action = ACT_TRAP;
      end
`endif
    end
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    pc_d    = PC;
    valid_d = (state_d == RUN);
    wrap_d  = 1'b0;
    mis_d   = 1'b0;
`ifdef PC_TRAP_EN
    epc_d   = Epc;
`endif
    case (action)
`ifdef PC_TRAP_EN
      ACT_TRAP: begin
        epc_d = PC;
        pc_d  = TRAP_VEC;
      end
`endif
      ACT_JUMP: begin
        if (jump_wraps) begin
          pc_d   = RESET_VEC;
          wrap_d = 1'b1;
        end else begin
          pc_d   = RedirectAddr;
        end
      end
      ACT_REJECT: begin
        mis_d = 1'b1;
      end
      ACT_STEP: begin
        if (inc_wraps) begin
          pc_d   = RESET_VEC;
          wrap_d = 1'b1;
        end else begin
          pc_d   = inc_sum[WIDTH-1:0];
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      PC         <= RESET_VEC;
      PCValid    <= 1'b0;
      Wrap       <= 1'b0;
      Misaligned <= 1'b0;
    end else begin
      PC         <= pc_d;
      PCValid    <= valid_d;
      Wrap       <= wrap_d;
      Misaligned <= mis_d;
    end
  end

`ifdef PC_TRAP_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Epc <= '0;
    end else begin
      Epc <= epc_d;
    end
  end
`endif

endmodule
